keypad_scanner: RTL and testbench

//  Parametrised successor to the 4x4 keypad scanner: drives one-cold columns of an NUM_ROWS x NUM_COLS matrix,

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: drives one-cold columns, debounces each key once per frame and
// queues press events (key index = c*NUM_ROWS + r) in a show-ahead FIFO with a
// valid/ready read port.
// Optional feature macro: KEYSCAN_RELEASE_EVT_EN -- when defined, releases are queued too,
// with key_release=1.
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SCAN_US        = 1000,
    parameter int unsigned SETTLE_US      = 1,
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned NUM_KEYS      = NUM_ROWS * NUM_COLS,
    localparam int unsigned KW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [KW-1:0]       key_code,
    output logic                key_release,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_down,
    output logic                overflow
);

    localparam int unsigned DWELL     = CLK_HZ / 1_000_000 * SCAN_US;
    localparam int unsigned SETTLE    = CLK_HZ / 1_000_000 * SETTLE_US;
    localparam int unsigned SETTLE_AT = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int unsigned TW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned CIW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned RIW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned DW        = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
`ifdef KEYSCAN_RELEASE_EVT_EN
    localparam int unsigned EW        = KW + 1;
`else
    localparam int unsigned EW        = KW;
`endif

    if (DWELL <= SETTLE + NUM_ROWS + 1) begin : g_bad_dwell
        $error("keypad_scanner: DWELL must exceed SETTLE + NUM_ROWS + 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keypad_scanner: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {StDrive, StSample, StEnq, StWait} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [CIW-1:0]    col_idx_q, col_idx_d;
    logic [RIW-1:0]    row_idx_q, row_idx_d;
    logic              last_tick;

    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [DW-1:0]       cnt_q [NUM_KEYS];
    logic [DW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_ROWS-1:0] evt_q, evt_d;
`ifdef KEYSCAN_RELEASE_EVT_EN
    logic [NUM_ROWS-1:0] rel_q, rel_d;
`endif

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              empty, full, push, pop, push_ok;
    logic [KW-1:0]     push_code;
    logic [EW-1:0]     push_ent, head;
    logic              overflow_q;

    assign last_tick = (tick_q == TW'(DWELL - 1));

    // Scan sequencing: tick/column counters and per-column phase FSM
    always_comb begin
        tick_d    = last_tick ? '0 : tick_q + 1'b1;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        state_d   = state_q;
        if (last_tick) begin
            col_idx_d = (col_idx_q == CIW'(NUM_COLS - 1)) ? '0 : col_idx_q + 1'b1;
        end
        case (state_q)
            StDrive:  if (tick_q == TW'(SETTLE_AT)) state_d = StSample;
            StSample: begin
                state_d   = StEnq;
                row_idx_d = '0;
            end
            StEnq: begin
                if (row_idx_q == RIW'(NUM_ROWS - 1)) begin
                    state_d = StWait;
                end else begin
                    row_idx_d = row_idx_q + 1'b1;
                end
            end
            StWait:   if (last_tick) state_d = StDrive;
            default:  state_d = StDrive;
        endcase
    end

    // Per-key debounce for the driven column, evaluated once per frame at SAMPLE
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        evt_d    = evt_q;
`ifdef KEYSCAN_RELEASE_EVT_EN
        rel_d    = rel_q;
`endif
        if (state_q == StSample) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (col_idx_q == CIW'(c)) begin
                        evt_d[r] = 1'b0;
                        if (!row[r] != stable_q[c*NUM_ROWS+r]) begin
                            if (cnt_q[c*NUM_ROWS+r] == DW'(DEBOUNCE_SCANS - 1)) begin
                                stable_d[c*NUM_ROWS+r] = !stable_q[c*NUM_ROWS+r];
                                cnt_d[c*NUM_ROWS+r]    = '0;
`ifdef KEYSCAN_RELEASE_EVT_EN
                                evt_d[r] = 1'b1;
                                rel_d[r] = stable_q[c*NUM_ROWS+r];
`else
                                evt_d[r] = !stable_q[c*NUM_ROWS+r];
`endif
                            end else begin
                                cnt_d[c*NUM_ROWS+r] = cnt_q[c*NUM_ROWS+r] + 1'b1;
                            end
                        end else begin
                            cnt_d[c*NUM_ROWS+r] = '0;
                        end
                    end
                end
            end
        end
    end

    // FIFO control: one candidate push per ENQ cycle, pop on handshake
    always_comb begin
        push_code = KW'(col_idx_q) * KW'(NUM_ROWS) + KW'(row_idx_q);
        push      = (state_q == StEnq) && evt_q[row_idx_q];
`ifdef KEYSCAN_RELEASE_EVT_EN
        push_ent  = {rel_q[row_idx_q], push_code};
`else
        push_ent  = push_code;
`endif
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = !empty && key_ready;
        // A full FIFO still accepts when the head leaves in the same cycle
        push_ok   = push && (!full || pop);
        head      = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Scanner state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StDrive;
            tick_q    <= '0;
            col_idx_q <= '0;
            row_idx_q <= '0;
            stable_q  <= '0;
            evt_q     <= '0;
`ifdef KEYSCAN_RELEASE_EVT_EN
            rel_q     <= '0;
`endif
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            stable_q  <= stable_d;
            evt_q     <= evt_d;
`ifdef KEYSCAN_RELEASE_EVT_EN
            rel_q     <= rel_d;
`endif
            cnt_q     <= cnt_d;
        end
    end

    // Event FIFO storage, pointers and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            overflow_q <= push && full && !pop;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign col       = ~(NUM_COLS'(1) << col_idx_q);
    assign key_valid = !empty;
    assign key_code  = head[KW-1:0];
`ifdef KEYSCAN_RELEASE_EVT_EN
    assign key_release = head[KW];
`else
    assign key_release = 1'b0;
`endif
    assign key_down  = |stable_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level keypad model (cycle count -> column/phase,
// per-key debounce counters, event queue) checked against the DUT every cycle, plus
// directed scenarios with hand-computed event lists.
`timescale 1ns/1ps

module tb_keypad_scanner;

    localparam int NR = 4, NC = 4, DWELL = 10, SETTLE = 2, DS = 3, DEPTH = 4;
    localparam int FRAME = NC * DWELL;
`ifdef KEYSCAN_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_release, key_valid, key_ready, key_down, overflow;
    logic [15:0] pressed = '0;

    int n_pass = 0, n_total = 0;

    // model state
    int         m_k;
    bit         m_stable [16];
    int         m_cnt [16];
    bit         m_flag [4];
    bit         m_rel [4];
    logic [4:0] m_q [$];
    bit         m_ovf;

    // observation logs
    logic [4:0] pop_log [$];
    int         ovf_cnt;
    bit         kd_seen;

    always #5 clk = ~clk;

    // keypad matrix: a held key pulls its row low while its column is driven low
    always_comb begin
        row = '1;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (!col[c] && pressed[c*NR+r]) row[r] = 1'b0;
    end

    keypad_scanner #(
        .CLK_HZ(1_000_000), .SCAN_US(10), .SETTLE_US(2), .NUM_ROWS(4), .NUM_COLS(4),
        .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_release(key_release), .key_valid(key_valid), .key_ready(key_ready),
        .key_down(key_down), .overflow(overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_k = 0;
        m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_stable[i] = 1'b0;
            m_cnt[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_flag[i] = 1'b0;
            m_rel[i] = 1'b0;
        end
    endtask

    // one clock of the keypad model, using pre-edge inputs
    task automatic model_step();
        int t, c, r, key;
        bit do_pop, full, do_push;
        logic [4:0] ent;
        t = m_k % DWELL;
        c = (m_k / DWELL) % NC;
        do_pop = (m_q.size() > 0) && key_ready;
        full = (m_q.size() == DEPTH);
        do_push = 1'b0;
        m_ovf = 1'b0;
        ent = '0;
        if (t == SETTLE) begin
            for (int i = 0; i < NR; i++) begin
                key = c * NR + i;
                m_flag[i] = 1'b0;
                if (pressed[key] != m_stable[key]) begin
                    m_cnt[key]++;
                    if (m_cnt[key] == DS) begin
                        m_stable[key] = pressed[key];
                        m_cnt[key] = 0;
                        m_flag[i] = m_stable[key] || REL_EN;
                        m_rel[i] = !m_stable[key];
                    end
                end else begin
                    m_cnt[key] = 0;
                end
            end
        end
        if (t > SETTLE && t <= SETTLE + NR) begin
            r = t - SETTLE - 1;
            if (m_flag[r]) begin
                ent = {m_rel[r], 4'(c * NR + r)};
                if (!full || do_pop) do_push = 1'b1;
                else m_ovf = 1'b1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(ent);
        m_k++;
    endtask

    function automatic bit model_down();
        bit d = 1'b0;
        for (int i = 0; i < 16; i++) d |= m_stable[i];
        return d;
    endfunction

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial begin : compare
        logic [3:0] exp_col;
        forever begin
            @(negedge clk);
            exp_col = 4'b1111;
            exp_col[(m_k / DWELL) % NC] = 1'b0;
            check("col", int'(col), int'(exp_col));
            check("key_valid", int'(key_valid), int'(m_q.size() > 0));
            check("key_down", int'(key_down), int'(model_down()));
            check("overflow", int'(overflow), int'(m_ovf));
            if (m_q.size() > 0) begin
                check("key_code", int'(key_code), int'(m_q[0][3:0]));
                check("key_release", int'(key_release), int'(m_q[0][4]));
            end
            if (key_valid && key_ready) pop_log.push_back({key_release, key_code});
            if (overflow) ovf_cnt++;
            if (key_down) kd_seen = 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        ovf_cnt = 0;
        kd_seen = 1'b0;
    endtask

    function automatic int log_at(input int i);
        return (pop_log.size() > i) ? int'(pop_log[i]) : -1;
    endfunction

    initial begin : stim
        key_ready = 1'b1;
        clear_logs();
        rst = 1'b1;
        #1;
        check("reset col", int'(col), 4'b1110);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_code", int'(key_code), 0);
        check("reset key_release", int'(key_release), 0);
        check("reset key_down", int'(key_down), 0);
        check("reset overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // key 9 (col 2, row 1) held for 10 frames -> single press event
        clear_logs();
        pressed[9] = 1'b1;
        cycles(10 * FRAME);
        check("held key_down", int'(key_down), 1);
        pressed = '0;
        cycles(5 * FRAME);
        check("held event count", pop_log.size(), REL_EN ? 2 : 1);
        check("held event 0", log_at(0), 9);
        if (REL_EN) check("held event 1", log_at(1), 16 + 9);

        // bounce: two samples only -> nothing
        clear_logs();
        pressed[2] = 1'b1;
        cycles(2 * FRAME);
        pressed = '0;
        cycles(4 * FRAME);
        check("bounce event count", pop_log.size(), 0);
        check("bounce key_down seen", int'(kd_seen), 0);

        // consumer stalled, five presses one frame apart -> four queued, one dropped
        clear_logs();
        key_ready = 1'b0;
        pressed[0] = 1'b1;  cycles(FRAME);
        pressed[5] = 1'b1;  cycles(FRAME);
        pressed[10] = 1'b1; cycles(FRAME);
        pressed[15] = 1'b1; cycles(FRAME);
        pressed[3] = 1'b1;  cycles(5 * FRAME);
        check("overflow pulses", ovf_cnt, 1);
        check("stalled key_valid", int'(key_valid), 1);
        check("stalled head", int'(key_code), 0);
        key_ready = 1'b1;
        cycles(6);
        check("drain count", pop_log.size(), 4);
        check("drain 0", log_at(0), 0);
        check("drain 1", log_at(1), 5);
        check("drain 2", log_at(2), 10);
        check("drain 3", log_at(3), 15);
        pressed = '0;
        cycles(5 * FRAME);

        // two keys in column 1 together -> 4 then 7
        clear_logs();
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        cycles(5 * FRAME);
        check("pair count", pop_log.size(), 2);
        check("pair 0", log_at(0), 4);
        check("pair 1", log_at(1), 7);
        pressed = '0;
        cycles(5 * FRAME);

        // key 6 press then release
        clear_logs();
        pressed[6] = 1'b1;
        cycles(5 * FRAME);
        pressed = '0;
        cycles(5 * FRAME);
        check("key6 count", pop_log.size(), REL_EN ? 2 : 1);
        check("key6 press", log_at(0), 6);
        if (REL_EN) check("key6 release", log_at(1), 16 + 6);

        // asynchronous reset mid-scan with two events pending
        key_ready = 1'b0;
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        cycles(5 * FRAME + 13);
        check("pre-reset key_valid", int'(key_valid), 1);
        check("pre-reset key_down", int'(key_down), 1);
        #2 rst = 1'b1;
        #1;
        check("async reset col", int'(col), 4'b1110);
        check("async reset key_valid", int'(key_valid), 0);
        check("async reset key_down", int'(key_down), 0);
        pressed = '0;
        key_ready = 1'b1;
        clear_logs();
        cycles(2);
        rst = 1'b0;
        cycles(3 * FRAME);
        check("post-reset events", pop_log.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
